// File: rtl/shift_pkg.sv
// Shared state and mode encodings for the sequential left shifter.
package shift_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } shift_state_t;

   localparam logic MODE_LOGICAL = 1'b0;
   localparam logic MODE_ROTATE  = 1'b1;

endpackage

// File: rtl/left_shift_sequencer.sv
// Sequential left shifter: loads a word, then shifts or rotates it left one bit per clock.
// Reports the last carry-out and a sticky signed-overflow flag.
module left_shift_sequencer
   import shift_pkg::*;
#(
   parameter int width = 16,
   parameter int AW    = $clog2(width + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [width-1:0] din,
   input  logic [AW-1:0]    amount,
   input  logic             mode,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] dout,
   output logic             carry,
   output logic             ovf
);

   shift_state_t     state_q;
   logic [AW-1:0]    count_q;
   logic             mode_q;
   logic [width-1:0] dout_q;
   logic             carry_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   logic [width-1:0] dout_d;
   logic             ovf_d;
   logic [AW-1:0]    count_d;

   // One shift step, plus the load count saturated so amounts above width cost width steps.
   always_comb begin
      // NOTE: every combinational output is given a default first, so no path can infer a latch.
      dout_d  = {dout_q[width-2:0], 1'b0};
      ovf_d   = ovf_q;
      count_d = amount;
      if (mode_q == MODE_ROTATE) begin
         dout_d[0] = dout_q[width-1];
      end else begin
         ovf_d = ovf_q | (dout_q[width-1] ^ dout_q[width-2]);
      end
      if (amount > AW'(width)) begin
         count_d = AW'(width);
      end
   end

   // NOTE: all state updates use non-blocking assignments so each register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         mode_q  <= MODE_LOGICAL;
         dout_q  <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  dout_q  <= din;
                  count_q <= count_d;
                  mode_q  <= mode;
                  carry_q <= 1'b0;
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               // The extra count==0 cycle is where the result is declared final.
               if (count_q != '0) begin
                  dout_q  <= dout_d;
                  carry_q <= dout_q[width-1];
                  ovf_q   <= ovf_d;
                  count_q <= count_q - AW'(1);
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign dout  = dout_q;
   assign carry = carry_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_left_shift_sequencer.sv
// Scoreboard bench for left_shift_sequencer: directed operations queue their expected
// result and completion cycle; a monitor checks each done pulse against the queue.
module tb_left_shift_sequencer;

   localparam int W  = 16;
   localparam int AW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  din = '0;
   logic [AW-1:0] amount = '0;
   logic          mode = 1'b0;
   logic          busy, done, carry, ovf;
   logic [W-1:0]  dout;

   typedef struct {
      string        name;
      logic [W-1:0] dout;
      logic         carry;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   left_shift_sequencer #(.width(W), .AW(AW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .din    (din),
      .amount (amount),
      .mode   (mode),
      .busy   (busy),
      .done   (done),
      .dout   (dout),
      .carry  (carry),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_dout"},  32'(dout),  32'(e.dout));
            check({e.name, "_carry"}, 32'(carry), 32'(e.carry));
            check({e.name, "_ovf"},   32'(ovf),   32'(e.ovf));
            check({e.name, "_cycle"}, 32'(cyc),   32'(e.cyc));
            check({e.name, "_busy"},  32'(busy),  32'(0));
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at the negedge after the start edge.
   task automatic issue(input string nm, input logic [W-1:0] d, input logic [AW-1:0] a,
                        input logic m, input logic [W-1:0] ed, input logic ec,
                        input logic eo, input int n);
      exp_t e;
      e.name = nm; e.dout = ed; e.carry = ec; e.ovf = eo; e.cyc = cyc + n + 2;
      sb.push_back(e);
      start = 1'b1; din = d; amount = a; mode = m;
      @(negedge clk);
      start = 1'b0;
      din = $urandom; amount = AW'($urandom); mode = 1'($urandom);
      check({nm, "_busy_after_start"}, 32'(busy), 32'(1));
   endtask

   task automatic drain(input string nm);
      int i;
      for (i = 0; i < 100 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      check({nm, "_drain_timeout"}, 32'(sb.size()), 32'(0));
      @(negedge clk);
   endtask

   initial begin
      int bc;
      int k;
      // Reset with random inputs; outputs must clear before any clock edge.
      start = 1'b1; din = $urandom; amount = AW'($urandom); mode = 1'($urandom);
      #1 rst_n = 1'b0;
      #2;
      check("rst_busy",  32'(busy),  32'(0));
      check("rst_done",  32'(done),  32'(0));
      check("rst_dout",  32'(dout),  32'(0));
      check("rst_carry", 32'(carry), 32'(0));
      check("rst_ovf",   32'(ovf),   32'(0));
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Logical shift by 4; busy spans exactly 5 cycles.
      issue("lsl4", 16'h0001, 5'd4, 1'b0, 16'h0010, 1'b0, 1'b0, 4);
      bc = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) bc++;
         else break;
      end
      check("lsl4_busy_cycles", 32'(bc), 32'(5));
      drain("lsl4");

      issue("ovf1", 16'h4000, 5'd1, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
      drain("ovf1");

      issue("rol4", 16'h8001, 5'd4, 1'b1, 16'h0018, 1'b0, 1'b0, 4);
      drain("rol4");

      issue("sat31", 16'hFFFF, 5'd31, 1'b0, 16'h0000, 1'b1, 1'b1, 16);
      drain("sat31");

      issue("zero", 16'hA5A5, 5'd0, 1'b0, 16'hA5A5, 1'b0, 1'b0, 0);
      drain("zero");

      // Start pulsed while busy must be ignored.
      issue("busy_start", 16'h0003, 5'd2, 1'b0, 16'h000C, 1'b0, 1'b0, 2);
      start = 1'b1; din = 16'hFFFF; amount = 5'd1; mode = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain("busy_start");

      // Reset mid-shift: immediate clear, no done pulse, then a clean operation.
      issue("aborted", 16'hFFFF, 5'd16, 1'b0, 16'h0000, 1'b1, 1'b1, 16);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",  32'(busy),  32'(0));
      check("midrst_dout",  32'(dout),  32'(0));
      check("midrst_carry", 32'(carry), 32'(0));
      check("midrst_ovf",   32'(ovf),   32'(0));
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_done", 32'(done), 32'(0));
      end
      issue("post_rst", 16'h0001, 5'd15, 1'b0, 16'h8000, 1'b0, 1'b1, 15);
      drain("post_rst");

      // Back-to-back: second start presented in the done cycle of the first.
      issue("b2b_a", 16'hC000, 5'd2, 1'b1, 16'h0003, 1'b1, 1'b0, 2);
      k = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("b2b_done_seen", 32'(done), 32'(1));
      issue("b2b_b", 16'h7FFF, 5'd1, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1);
      check("b2b_done_dropped", 32'(done), 32'(0));
      drain("b2b_b");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
